// File: rtl/alu_issue_arbiter.sv
// Two-port issue arbiter in front of the shared RV32I ALU: port 0 has priority, port 1 has starvation relief.
// Fixed 2-cycle pipeline (operand register, result register); ALU_ARB_STATS_EN adds saturating grant/conflict counters.
module alu_issue_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [3:0]       req1_ctrl,
  output logic [31:0]      AluOp1,
  output logic [31:0]      AluOp2,
  output logic [3:0]       AluCtrl,
  input  logic [31:0]      AluOut,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [31:0]      rsp_data
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_grant0,
  output logic [CNT_W-1:0] stat_grant1,
  output logic [CNT_W-1:0] stat_conflict
`endif
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_W < 1) begin : g_param_check
    $error("alu_issue_arbiter: STARVE_LIMIT must be 1..15 and CNT_W at least 1");
  end

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    TAG_P0 = 1'b0,
    TAG_P1 = 1'b1
  } tag_e;

  logic [3:0]  r_starve_cnt;
  logic        r_s1_vld;
  tag_e        r_s1_tag;
  logic [31:0] r_alu_op1;
  logic [31:0] r_alu_op2;
  logic [3:0]  r_alu_ctrl;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp_data;

  logic        w_starve_hit;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [31:0] w_sel_op1;
  logic [31:0] w_sel_op2;
  logic [3:0]  w_sel_ctrl;

  // Ready of an idle port stays high unless the other port holds the grant.
  always_comb begin
    w_starve_hit = (r_starve_cnt == LIMIT);
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    if (!rst && !clear) begin
      w_grant0 = req0_valid && !(req1_valid && w_starve_hit);
      w_grant1 = req1_valid && (!req0_valid || w_starve_hit);
    end
    w_accept   = w_grant0 || w_grant1;
    w_sel_op1  = w_grant1 ? req1_op1  : req0_op1;
    w_sel_op2  = w_grant1 ? req1_op2  : req0_op2;
    w_sel_ctrl = w_grant1 ? req1_ctrl : req0_ctrl;
    req0_ready = !rst && !clear && !w_grant1;
    req1_ready = !rst && !clear && !w_grant0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_tag     <= TAG_P0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_ctrl   <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      if (clear || !req1_valid || w_grant1) begin
        r_starve_cnt <= '0;
      end else if (!w_starve_hit) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_tag   <= w_grant1 ? TAG_P1 : TAG_P0;
        r_alu_op1  <= w_sel_op1;
        r_alu_op2  <= w_sel_op2;
        r_alu_ctrl <= w_sel_ctrl;
      end

      // A flush also cancels the result that would have been returned at this edge.
      if (clear) begin
        r_rsp0_valid <= 1'b0;
        r_rsp1_valid <= 1'b0;
      end else begin
        r_rsp0_valid <= r_s1_vld && (r_s1_tag == TAG_P0);
        r_rsp1_valid <= r_s1_vld && (r_s1_tag == TAG_P1);
      end
      if (r_s1_vld) begin
        r_rsp_data <= AluOut;
      end
    end
  end

  assign AluOp1     = r_alu_op1;
  assign AluOp2     = r_alu_op2;
  assign AluCtrl    = r_alu_ctrl;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_data   = r_rsp_data;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat_grant0;
  logic [CNT_W-1:0] r_stat_grant1;
  logic [CNT_W-1:0] r_stat_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_grant0   <= '0;
      r_stat_grant1   <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_grant0 && (r_stat_grant0 != '1)) begin
        r_stat_grant0 <= r_stat_grant0 + 1'b1;
      end
      if (w_grant1 && (r_stat_grant1 != '1)) begin
        r_stat_grant1 <= r_stat_grant1 + 1'b1;
      end
      if (req0_valid && req1_valid && !clear && (r_stat_conflict != '1)) begin
        r_stat_conflict <= r_stat_conflict + 1'b1;
      end
    end
  end

  assign stat_grant0   = r_stat_grant0;
  assign stat_grant1   = r_stat_grant1;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule
